// File: rtl/pc_gen.sv
// Program-counter generator at the head of fetch: boot, sequential fetch with stall,
// prioritised trap/branch redirects, halt/resume and misaligned-branch reporting.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter int unsigned     INSTR_BYTES  = 4,
  parameter int unsigned     ALIGN_BITS   = $clog2(INSTR_BYTES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_ready,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_target,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            pc_valid,
  output logic            halted,
  output logic            misalign_err,
  output logic [XLEN-1:0] misalign_addr
);

  localparam logic [XLEN-1:0] STEP     = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] LOW_MASK = XLEN'((64'(1) << ALIGN_BITS) - 64'(1));

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [XLEN-1:0] pc_d;
  logic            pc_valid_d;
  logic            halted_d;
  logic            misalign_err_d;
  logic [XLEN-1:0] misalign_addr_d;

  logic [XLEN-1:0] trap_aligned;
  logic            br_misaligned;

  assign trap_aligned  = trap_target & ~LOW_MASK;
  assign br_misaligned = |(br_target & LOW_MASK);
  assign pc_plus       = pc + STEP;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= BOOT;
      pc            <= RESET_VECTOR;
      pc_valid      <= 1'b0;
      halted        <= 1'b0;
      misalign_err  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      state         <= state_d;
      pc            <= pc_d;
      pc_valid      <= pc_valid_d;
      halted        <= halted_d;
      misalign_err  <= misalign_err_d;
      misalign_addr <= misalign_addr_d;
    end
  end

  // Next-state and next-output logic; the presented pc is discarded on any redirect.
  always_comb begin
    state_d         = state;
    pc_d            = pc;
    misalign_err_d  = 1'b0;
    misalign_addr_d = misalign_addr;

    unique case (state)
      BOOT: begin
        state_d = RUN;
        if (trap_req) begin
          pc_d = trap_aligned;
        end
      end

      RUN: begin
        if (trap_req) begin
          pc_d = trap_aligned;
        end else if (br_taken && !br_misaligned) begin
          pc_d = br_target;
          if (halt_req) begin
            state_d = HALT;
          end
        end else begin
          // A misaligned branch only reports; the pc continues as if no branch.
          if (br_taken) begin
            misalign_err_d  = 1'b1;
            misalign_addr_d = br_target;
          end
          if (fetch_ready) begin
            pc_d = pc_plus;
          end
          if (halt_req) begin
            state_d = HALT;
          end
        end
      end

      HALT: begin
        if (trap_req) begin
          pc_d    = trap_aligned;
          state_d = RUN;
        end else if (resume) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = BOOT;
        pc_d    = RESET_VECTOR;
      end
    endcase

    pc_valid_d = (state_d == RUN);
    halted_d   = (state_d == HALT);
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with RESET_VECTOR=0x1000 and 4-byte fetch.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_ready;
  logic        br_taken;
  logic [31:0] br_target;
  logic        trap_req;
  logic [31:0] trap_target;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic        pc_valid;
  logic        halted;
  logic        misalign_err;
  logic [31:0] misalign_addr;

  int n_checks = 0;
  int n_fail   = 0;

  pc_gen #(
    .XLEN        (32),
    .RESET_VECTOR(32'h0000_1000),
    .INSTR_BYTES (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_ready  (fetch_ready),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .trap_req     (trap_req),
    .trap_target  (trap_target),
    .halt_req     (halt_req),
    .resume       (resume),
    .pc           (pc),
    .pc_plus      (pc_plus),
    .pc_valid     (pc_valid),
    .halted       (halted),
    .misalign_err (misalign_err),
    .misalign_addr(misalign_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] epc, input logic evalid,
                              input logic ehalt, input logic eerr);
    check({tag, ".pc"}, pc, epc);
    check({tag, ".pc_plus"}, pc_plus, epc + 32'd4);
    check({tag, ".pc_valid"}, 32'(pc_valid), 32'(evalid));
    check({tag, ".halted"}, 32'(halted), 32'(ehalt));
    check({tag, ".misalign_err"}, 32'(misalign_err), 32'(eerr));
  endtask

  task automatic idle_inputs();
    fetch_ready = 1'b0;
    br_taken    = 1'b0;
    br_target   = '0;
    trap_req    = 1'b0;
    trap_target = '0;
    halt_req    = 1'b0;
    resume      = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    fetch_ready = 1'b1;
    br_taken    = 1'b1;
    br_target   = 32'h0000_5000;

    // Reset held for three edges overrides active inputs
    repeat (3) step();
    expect_state("reset", 32'h1000, 1'b0, 1'b0, 1'b0);
    check("reset.misalign_addr", misalign_addr, 32'h0);

    // BOOT edge ignores branch, halt and fetch_ready
    reset    = 1'b1;
    halt_req = 1'b1;
    step();
    expect_state("boot", 32'h1000, 1'b1, 1'b0, 1'b0);

    // Sequential fetch then stall
    idle_inputs();
    fetch_ready = 1'b1;
    step(); expect_state("fetch1", 32'h1004, 1'b1, 1'b0, 1'b0);
    step(); expect_state("fetch2", 32'h1008, 1'b1, 1'b0, 1'b0);
    step(); expect_state("fetch3", 32'h100C, 1'b1, 1'b0, 1'b0);
    fetch_ready = 1'b0;
    step(); expect_state("stall1", 32'h100C, 1'b1, 1'b0, 1'b0);
    step(); expect_state("stall2", 32'h100C, 1'b1, 1'b0, 1'b0);

    // Trap beats branch and halt; target low bits cleared
    trap_req    = 1'b1;
    trap_target = 32'h0000_8003;
    br_taken    = 1'b1;
    br_target   = 32'h0000_2000;
    halt_req    = 1'b1;
    step(); expect_state("trap_prio", 32'h8000, 1'b1, 1'b0, 1'b0);

    idle_inputs();
    br_taken  = 1'b1;
    br_target = 32'h0000_2000;
    step(); expect_state("branch", 32'h2000, 1'b1, 1'b0, 1'b0);

    // Misaligned branch at 0x3000 with fetch_ready: pc advances, one-cycle pulse
    br_target = 32'h0000_3000;
    step(); expect_state("br3000", 32'h3000, 1'b1, 1'b0, 1'b0);
    br_target   = 32'h0000_2002;
    fetch_ready = 1'b1;
    step(); expect_state("misalign", 32'h3004, 1'b1, 1'b0, 1'b1);
    check("misalign.addr", misalign_addr, 32'h2002);
    idle_inputs();
    step(); expect_state("misalign_end", 32'h3004, 1'b1, 1'b0, 1'b0);
    check("misalign_end.addr", misalign_addr, 32'h2002);

    // Back-to-back misaligned branches
    br_taken  = 1'b1;
    br_target = 32'h0000_0011;
    step(); expect_state("b2b1", 32'h3004, 1'b1, 1'b0, 1'b1);
    check("b2b1.addr", misalign_addr, 32'h0011);
    br_target = 32'h0000_0023;
    step(); expect_state("b2b2", 32'h3004, 1'b1, 1'b0, 1'b1);
    check("b2b2.addr", misalign_addr, 32'h0023);
    idle_inputs();
    step(); expect_state("b2b_end", 32'h3004, 1'b1, 1'b0, 1'b0);
    check("b2b_end.addr", misalign_addr, 32'h0023);

    // Halt with fetch_ready at 0x4000
    br_taken  = 1'b1;
    br_target = 32'h0000_4000;
    step(); expect_state("br4000", 32'h4000, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    halt_req    = 1'b1;
    fetch_ready = 1'b1;
    step(); expect_state("halt", 32'h4004, 1'b0, 1'b1, 1'b0);
    idle_inputs();
    fetch_ready = 1'b1;
    br_taken    = 1'b1;
    br_target   = 32'h0000_6000;
    step(); expect_state("halt_br_ign", 32'h4004, 1'b0, 1'b1, 1'b0);
    idle_inputs();
    resume = 1'b1;
    step(); expect_state("resume", 32'h4004, 1'b1, 1'b0, 1'b0);

    // Halt again without fetch_ready, exit through trap
    idle_inputs();
    halt_req = 1'b1;
    step(); expect_state("halt2", 32'h4004, 1'b0, 1'b1, 1'b0);
    idle_inputs();
    trap_req    = 1'b1;
    trap_target = 32'h0000_0100;
    step(); expect_state("halt_trap", 32'h0100, 1'b1, 1'b0, 1'b0);

    // Aligned branch with halt: load target then halt
    idle_inputs();
    br_taken  = 1'b1;
    br_target = 32'h0000_7000;
    halt_req  = 1'b1;
    step(); expect_state("br_halt", 32'h7000, 1'b0, 1'b1, 1'b0);
    idle_inputs();
    resume = 1'b1;
    step(); expect_state("br_halt_res", 32'h7000, 1'b1, 1'b0, 1'b0);

    // Wrap at top of address space
    idle_inputs();
    br_taken  = 1'b1;
    br_target = 32'hFFFF_FFFC;
    step(); expect_state("top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    fetch_ready = 1'b1;
    step(); expect_state("wrap", 32'h0000_0000, 1'b1, 1'b0, 1'b0);

    // Leave a misalign address behind, then mid-run reset with a pending branch
    br_taken  = 1'b1;
    br_target = 32'h0000_0042;
    step(); check("pre_rst.addr", misalign_addr, 32'h0042);
    reset     = 1'b0;
    br_target = 32'h0000_2000;
    step(); expect_state("midrst", 32'h1000, 1'b0, 1'b0, 1'b0);
    check("midrst.addr", misalign_addr, 32'h0);

    // Trap during BOOT redirects and enters RUN
    idle_inputs();
    reset       = 1'b1;
    trap_req    = 1'b1;
    trap_target = 32'h0000_9006;
    step(); expect_state("boot_trap", 32'h9004, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
